// File: rtl/adder_arb_pkg.sv
// Shared types and default widths for the adder_arbiter slice.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 32;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester/consumer bundle for adder_arbiter.
// rsp_ovf exists only when ADDER_ARB_OVF_EN is defined.
interface adder_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a_flat;
    logic [NREQ*W-1:0] op_b_flat;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;
`ifdef ADDER_ARB_OVF_EN
    logic              rsp_ovf;

    modport master (
        output req, op_a_flat, op_b_flat, rsp_ready,
        input  gnt, busy, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf
    );
    modport slave (
        input  req, op_a_flat, op_b_flat, rsp_ready,
        output gnt, busy, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf
    );
`else
    modport master (
        output req, op_a_flat, op_b_flat, rsp_ready,
        input  gnt, busy, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );
    modport slave (
        input  req, op_a_flat, op_b_flat, rsp_ready,
        output gnt, busy, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );
`endif

endinterface

// File: rtl/adder.sv
// Shared W-bit adder datapath; sequenced exclusively by adder_arbiter.
module adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, cyclically.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW:0]   pos;
    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            // ptr + i stays below 2*NREQ, so one conditional subtract wraps it
            pos = {1'b0, ptr} + (IDW+1)'(i);
            if (pos >= (IDW+1)'(NREQ))
                pos = pos - (IDW+1)'(NREQ);
            cand = pos[IDW-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sequencer for the shared adder: IDLE (arbitrate) -> EXEC -> RESP.
// ADDER_ARB_OVF_EN adds the registered signed-overflow flag rsp_ovf.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d, w_q, w_d, id_q, id_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            busy_q, busy_d, valid_q, valid_d, carry_q, carry_d;

    logic [NREQ-1:0] win_onehot;
    logic [IDW-1:0]  win_idx;
    logic            win_any;
    logic [W-1:0]    a_sel, b_sel, sum_w;
    logic [W:0]      wide;

`ifdef ADDER_ARB_OVF_EN
    logic ovf_q, ovf_d, ovf_w;
    assign ovf_w       = (a_q[W-1] == b_q[W-1]) && (sum_w[W-1] != a_q[W-1]);
    assign bus.rsp_ovf = ovf_q;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (win_onehot),
        .idx (win_idx),
        .any (win_any)
    );

    adder #(.W(W)) u_adder (
        .a   (a_q),
        .b   (b_q),
        .sum (sum_w)
    );

    // Carry comes from a local wide add; its low bits must agree with the shared adder
    assign wide = {1'b0, a_q} + {1'b0, b_q};
    assert property (@(posedge clk) disable iff (!rst_n) wide[W-1:0] == sum_w);

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                a_sel = bus.op_a_flat[i*W +: W];
                b_sel = bus.op_b_flat[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            w_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            id_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
`ifdef ADDER_ARB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        w_d     = w_q;
        a_d     = a_q;
        b_d     = b_q;
        gnt_d   = '0;
        valid_d = valid_q;
        id_d    = id_q;
        sum_d   = sum_q;
        carry_d = carry_q;
`ifdef ADDER_ARB_OVF_EN
        ovf_d   = ovf_q;
`endif
        busy_d  = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    gnt_d = win_onehot;
                    w_d   = win_idx;
                    a_d   = a_sel;
                    b_d   = b_sel;
                    ptr_d = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                end
            end
            EXEC: begin
                valid_d = 1'b1;
                id_d    = w_q;
                sum_d   = sum_w;
                carry_d = wide[W];
`ifdef ADDER_ARB_OVF_EN
                ovf_d   = ovf_w;
`endif
            end
            RESP: begin
                if (bus.rsp_ready) valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_carry = carry_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized self-checking bench for adder_arbiter against a transaction-level model.
// Overflow checks are compiled in when ADDER_ARB_OVF_EN is defined.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int ptr_m  = 0;

    logic [31:0] hold_id, hold_sum;
    logic        hold_carry;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        int c;
        for (int i = 0; i < NREQ; i++) begin
            c = (p + i) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [127:0] rep(input logic [31:0] v);
        return {4{v}};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [3:0] r, input logic [127:0] af, input logic [127:0] bf,
                          input int k, input bit keep);
        int w;
        logic [31:0] a, b;
        longint unsigned t;
        longint sv;
        logic [3:0] oh;
        bus.req       = r;
        bus.op_a_flat = af;
        bus.op_b_flat = bf;
        bus.rsp_ready = 1'($urandom);
        @(negedge clk);
        if (r == 4'b0000) begin
            check("idle_gnt", bus.gnt, 0);
            check("idle_busy", bus.busy, 0);
            check("idle_valid", bus.rsp_valid, 0);
            return;
        end
        w     = pick(r, ptr_m);
        ptr_m = (w + 1) % NREQ;
        a     = af[w*32 +: 32];
        b     = bf[w*32 +: 32];
        t     = longint'(a) + longint'(b);
        sv    = longint'($signed(a)) + longint'($signed(b));
        oh    = 4'b0001 << w;
        check("gnt", bus.gnt, oh);
        check("busy_exec", bus.busy, 1);
        check("valid_exec", bus.rsp_valid, 0);
        if (!keep) bus.req = 4'($urandom);
        bus.op_a_flat = {$urandom, $urandom, $urandom, $urandom};
        bus.op_b_flat = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        for (int j = 0; j <= k; j++) begin
            check("valid", bus.rsp_valid, 1);
            check("gnt_low", bus.gnt, 0);
            check("rsp_id", bus.rsp_id, w);
            check("rsp_sum", bus.rsp_sum, t & 64'hFFFF_FFFF);
            check("rsp_carry", bus.rsp_carry, t >> 32);
`ifdef ADDER_ARB_OVF_EN
            check("rsp_ovf", bus.rsp_ovf, (sv > 64'sd2147483647) || (sv < -64'sd2147483648));
`endif
            bus.rsp_ready = (j == k);
            @(negedge clk);
        end
        check("valid_done", bus.rsp_valid, 0);
        check("busy_done", bus.busy, 0);
        check("id_kept", bus.rsp_id, w);
        check("sum_kept", bus.rsp_sum, t & 64'hFFFF_FFFF);
        bus.req       = '0;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int w;
        rst_n         = 1'b0;
        bus.req       = 4'b1111;
        bus.op_a_flat = rep(32'd1);
        bus.op_b_flat = rep(32'd2);
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.rsp_valid, 0);
        check("rst_id", bus.rsp_id, 0);
        check("rst_sum", bus.rsp_sum, 0);
        check("rst_carry", bus.rsp_carry, 0);
        rst_n = 1'b1;

        // First grant after reset goes to requester 0
        run_op(4'b1111, rep(32'd3), rep(32'd4), 0, 1'b1);
        run_op(4'b0100, rep(32'd5), rep(32'd7), 0, 1'b0);
        for (int i = 0; i < 8; i++)
            run_op(4'b1111, {$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1);
        run_op(4'b0010, rep(32'hFFFF_FFFF), rep(32'd1), 5, 1'b0);
        run_op(4'b1000, rep(32'h7FFF_FFFF), rep(32'd1), 1, 1'b0);
        run_op(4'b0001, rep(32'h8000_0000), rep(32'h8000_0000), 0, 1'b0);

        for (int i = 0; i < 60; i++)
            run_op(4'($urandom_range(0, 15)),
                   {rand_op(), rand_op(), rand_op(), rand_op()},
                   {rand_op(), rand_op(), rand_op(), rand_op()},
                   $urandom_range(0, 3), 1'b0);

        // Reset while a response is pending
        bus.req       = 4'b1000;
        bus.op_a_flat = rep(32'd9);
        bus.op_b_flat = rep(32'd9);
        bus.rsp_ready = 1'b0;
        w     = pick(4'b1000, ptr_m);
        @(negedge clk);
        check("mid_gnt", bus.gnt, 4'b0001 << w);
        bus.req = '0;
        @(negedge clk);
        check("mid_valid", bus.rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.rsp_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_sum", bus.rsp_sum, 0);
        ptr_m = 0;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_stale_valid", bus.rsp_valid, 0);
        end
        bus.rsp_ready = 1'b0;
        run_op(4'b1111, rep(32'd20), rep(32'd22), 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
